trojan_response_checker: RTL

//  Consumer end of the exhaustive-stimulus/response stream: receives (pattern, DUT response) pairs

---
 rtl/trojan_chk_pkg.sv | 13 +
 rtl/misr_reg.sv | 40 ++++
 rtl/trojan_response_checker.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/trojan_chk_pkg.sv
// Shared types and constants for the trojan response checker.
package trojan_chk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chk_state_e;

   localparam logic [15:0] DEF_MISR_POLY = 16'h1021;
   localparam logic [15:0] DEF_MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/misr_reg.sv
// Single-input MISR: Galois-style shift with POLY feedback, data bit folded into bit 0.
// Latency 1; load has priority over shift; no backpressure.
module misr_reg #(
   parameter int               SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [SIG_W-1:0] seed,
   input  logic             shift_en,
   input  logic             din,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (load) begin
         sig_d = seed;
      end else if (shift_en) begin
         sig_d = {sig_q[SIG_W-2:0], 1'b0}
               ^ (sig_q[SIG_W-1] ? POLY : '0)
               ^ {{(SIG_W-1){1'b0}}, din};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/trojan_response_checker.sv
// Compares a stream of (pattern, response) pairs against a golden truth table and summarises the run.
// Latency 1 from accepting edge to outputs; resp_valid gaps of any length allowed, no backpressure.
module trojan_response_checker
   import trojan_chk_pkg::*;
#(
   parameter int               N_IN      = 5,
   parameter int               SIG_W     = 16,
   parameter logic [SIG_W-1:0] MISR_POLY = DEF_MISR_POLY,
   parameter logic [SIG_W-1:0] MISR_SEED = DEF_MISR_SEED
) (
   input  logic             CK,
   input  logic             reset,
   input  logic             gold_we,
   input  logic [N_IN-1:0]  gold_addr,
   input  logic             gold_bit,
   input  logic             start,
   input  logic             resp_valid,
   input  logic [N_IN-1:0]  resp_pattern,
   input  logic             resp_bit,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [N_IN:0]    mismatch_cnt,
   output logic             first_fail_vld,
   output logic [N_IN-1:0]  first_fail_pat,
   output logic             seq_err,
   output logic [SIG_W-1:0] signature
);

   localparam int             NPAT    = 1 << N_IN;
   localparam logic [N_IN:0]  CNT_MAX = (N_IN+1)'(NPAT);

   chk_state_e      state_q;
   logic            gold_q [NPAT];
   logic [N_IN-1:0] exp_pat_q;
   logic            busy_q, done_q, pass_q;
   logic [N_IN:0]   mismatch_cnt_q;
   logic            first_fail_vld_q;
   logic [N_IN-1:0] first_fail_pat_q;
   logic            seq_err_q;

   logic            start_ok;
   logic            accept;
   logic            mismatch;
   logic            last_pat;
   logic [N_IN:0]   mismatch_cnt_d;
   logic            seq_err_d;

   assign start_ok = start && (state_q != RUN);
   assign accept   = resp_valid && (state_q == RUN);
   // Compare indexes by the pattern actually applied, not the one we expected.
   assign mismatch = resp_bit != gold_q[resp_pattern];
   assign last_pat = exp_pat_q == {N_IN{1'b1}};

   always_comb begin
      mismatch_cnt_d = mismatch_cnt_q;
      if (mismatch && (mismatch_cnt_q != CNT_MAX)) begin
         mismatch_cnt_d = mismatch_cnt_q + 1'b1;
      end
      seq_err_d = seq_err_q | (resp_pattern != exp_pat_q);
   end

   // Table is deliberately left out of reset so contents survive a run abort.
   always_ff @(posedge CK) begin
      if (gold_we && (state_q != RUN)) begin
         gold_q[gold_addr] <= gold_bit;
      end
   end

   always_ff @(posedge CK) begin
      if (reset) begin
         state_q          <= IDLE;
         exp_pat_q        <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         pass_q           <= 1'b0;
         mismatch_cnt_q   <= '0;
         first_fail_vld_q <= 1'b0;
         first_fail_pat_q <= '0;
         seq_err_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_ok) begin
                  state_q          <= RUN;
                  exp_pat_q        <= '0;
                  busy_q           <= 1'b1;
                  done_q           <= 1'b0;
                  pass_q           <= 1'b0;
                  mismatch_cnt_q   <= '0;
                  first_fail_vld_q <= 1'b0;
                  first_fail_pat_q <= '0;
                  seq_err_q        <= 1'b0;
               end
            end
            RUN: begin
               if (accept) begin
                  exp_pat_q      <= exp_pat_q + 1'b1;
                  mismatch_cnt_q <= mismatch_cnt_d;
                  seq_err_q      <= seq_err_d;
                  if (mismatch && !first_fail_vld_q) begin
                     first_fail_vld_q <= 1'b1;
                     first_fail_pat_q <= resp_pattern;
                  end
                  if (last_pat) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (mismatch_cnt_d == '0) && !seq_err_d;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               pass_q  <= 1'b0;
            end
         endcase
      end
   end

   misr_reg #(
      .SIG_W (SIG_W),
      .POLY  (MISR_POLY)
   ) u_misr (
      .clk      (CK),
      .rst      (reset),
      .load     (start_ok),
      .seed     (MISR_SEED),
      .shift_en (accept),
      .din      (resp_bit),
      .sig      (signature)
   );

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign mismatch_cnt   = mismatch_cnt_q;
   assign first_fail_vld = first_fail_vld_q;
   assign first_fail_pat = first_fail_pat_q;
   assign seq_err        = seq_err_q;

endmodule
